// File: rtl/pe_tile_pkg.sv
// rtl/pe_tile_pkg.sv - shared feature ids, opcodes, SB selects and PE cfg bit positions
package pe_tile_pkg;

  localparam logic [15:0] FEAT_CONST   = 16'd3;
  localparam logic [15:0] FEAT_PE      = 16'd4;
  localparam logic [15:0] FEAT_CB1     = 16'd5;
  localparam logic [15:0] FEAT_CB0     = 16'd6;
  localparam logic [15:0] FEAT_SB_BASE = 16'd8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_MIN  = 3'd5,
    OP_MAX  = 3'd6,
    OP_PASS = 3'd7
  } pe_op_e;

  // Selects are relative to the driven side; codes 5..7 behave like SB_ZERO.
  typedef enum logic [2:0] {
    SB_ZERO    = 3'd0,
    SB_SIDE_P1 = 3'd1,
    SB_SIDE_P2 = 3'd2,
    SB_SIDE_P3 = 3'd3,
    SB_PE      = 3'd4
  } sb_sel_e;

  localparam int PE_CFG_W         = 6;
  localparam int PE_REG_OUT_BIT   = 3;
  localparam int PE_ACC_BIT       = 4;
  localparam int PE_USE_CONST_BIT = 5;

endpackage

// File: rtl/pe_tile_alu.sv
// rtl/pe_tile_alu.sv - combinational WIDTH-bit 8-op PE ALU, unsigned compare, wrapping add/sub
module pe_tile_alu
  import pe_tile_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  pe_op_e           op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_MIN:  y = (a < b) ? a : b;
      OP_MAX:  y = (a > b) ? a : b;
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/pe_tile_param.sv
// rtl/pe_tile_param.sv - PE tile: switch box, two connect boxes, PE with reg/acc modes
// Optional config readback enabled by defining PE_TILE_CFG_READBACK_EN.
module pe_tile_param
  import pe_tile_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_TRACKS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [31:0]                     config_addr,
  input  logic [31:0]                     config_data,
  input  logic                            config_we,
  input  logic                            config_rd_en,
  output logic [31:0]                     config_rd_data,
  input  logic [15:0]                     tile_id,
  input  logic [4*NUM_TRACKS*WIDTH-1:0]   in_tracks,
  output logic [4*NUM_TRACKS*WIDTH-1:0]   out_tracks
);

  localparam int NT       = NUM_TRACKS;
  localparam int CB_SEL_W = $clog2(2 * NT);
  localparam int SB_W     = 3 * NT;

  logic [15:0]          feat;
  logic                 match, wr;
  logic [WIDTH-1:0]     const_q, const_d;
  logic [PE_CFG_W-1:0]  pe_cfg_q, pe_cfg_d;
  logic [CB_SEL_W-1:0]  cb_q [2];
  logic [CB_SEL_W-1:0]  cb_d [2];
  logic [SB_W-1:0]      sb_q [4];
  logic [SB_W-1:0]      sb_d [4];
  logic [WIDTH-1:0]     pe_q, pe_d;

  logic [WIDTH-1:0]     in_t [4][NT];
  logic [WIDTH-1:0]     fb_t [2][NT];
  logic [WIDTH-1:0]     op_v [2];
  logic [WIDTH-1:0]     alu_a, alu_b, alu_y, pe_out, pe_fb;
  logic                 reg_out, acc, use_const;
  logic                 unused_ok;

  assign feat  = config_addr[31:16];
  assign match = (config_addr[15:0] == tile_id);
  assign wr    = config_we & match;
  assign unused_ok = ^{config_data, config_rd_en};

  function automatic logic [WIDTH-1:0] sb_pick(input logic [2:0] sel,
      input logic [WIDTH-1:0] v1, input logic [WIDTH-1:0] v2,
      input logic [WIDTH-1:0] v3, input logic [WIDTH-1:0] vpe);
    case (sb_sel_e'(sel))
      SB_SIDE_P1: return v1;
      SB_SIDE_P2: return v2;
      SB_SIDE_P3: return v3;
      SB_PE:      return vpe;
      default:    return '0;
    endcase
  endfunction

  always_comb begin
    for (int s = 0; s < 4; s++)
      for (int t = 0; t < NT; t++)
        in_t[s][t] = in_tracks[(s*NT+t)*WIDTH +: WIDTH];
  end

  // CBs read out tracks through a copy whose PE term is pe_reg or 0. Legal configs never
  // route a combinational PE result back into a CB, so this matches out_tracks there while
  // keeping the netlist free of a structural loop.
  always_comb begin
    for (int k = 0; k < 2; k++)
      for (int t = 0; t < NT; t++)
        fb_t[k][t] = sb_pick(sb_q[k][3*t +: 3], in_t[(k+1)%4][t], in_t[(k+2)%4][t],
                             in_t[(k+3)%4][t], pe_fb);
  end

  always_comb begin
    out_tracks = '0;
    for (int s = 0; s < 4; s++)
      for (int t = 0; t < NT; t++)
        out_tracks[(s*NT+t)*WIDTH +: WIDTH] = sb_pick(sb_q[s][3*t +: 3], in_t[(s+1)%4][t],
                                                      in_t[(s+2)%4][t], in_t[(s+3)%4][t], pe_out);
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      op_v[k] = '0;
      for (int j = 0; j < NT; j++) begin
        if (cb_q[k] == CB_SEL_W'(j))      op_v[k] = in_t[k][j];
        if (cb_q[k] == CB_SEL_W'(NT + j)) op_v[k] = fb_t[k][j];
      end
    end
  end

  assign reg_out   = pe_cfg_q[PE_REG_OUT_BIT];
  assign acc       = pe_cfg_q[PE_ACC_BIT] & reg_out;
  assign use_const = pe_cfg_q[PE_USE_CONST_BIT];
  assign alu_a     = acc ? pe_q : op_v[0];
  assign alu_b     = acc ? op_v[0] : (use_const ? const_q : op_v[1]);
  assign pe_out    = reg_out ? pe_q : alu_y;
  assign pe_fb     = reg_out ? pe_q : '0;

  pe_tile_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (pe_op_e'(pe_cfg_q[2:0])),
    .y  (alu_y)
  );

  always_comb begin
    const_d  = const_q;
    pe_cfg_d = pe_cfg_q;
    cb_d     = cb_q;
    sb_d     = sb_q;
    pe_d     = reg_out ? alu_y : '0;
    if (wr) begin
      if (feat == FEAT_CONST) const_d = config_data[WIDTH-1:0];
      if (feat == FEAT_CB0)   cb_d[0] = config_data[CB_SEL_W-1:0];
      if (feat == FEAT_CB1)   cb_d[1] = config_data[CB_SEL_W-1:0];
      if (feat == FEAT_PE) begin
        pe_cfg_d = config_data[PE_CFG_W-1:0];
        pe_d     = '0;
      end
      for (int s = 0; s < 4; s++)
        if (feat == FEAT_SB_BASE + 16'(s)) sb_d[s] = config_data[SB_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      const_q  <= '0;
      pe_cfg_q <= '0;
      pe_q     <= '0;
      for (int k = 0; k < 2; k++) cb_q[k] <= '0;
      for (int s = 0; s < 4; s++) sb_q[s] <= '0;
    end else begin
      const_q  <= const_d;
      pe_cfg_q <= pe_cfg_d;
      pe_q     <= pe_d;
      cb_q     <= cb_d;
      sb_q     <= sb_d;
    end
  end

`ifdef PE_TILE_CFG_READBACK_EN
  logic [31:0] rd_q, rd_d;

  always_comb begin
    rd_d = '0;
    if (config_rd_en && match) begin
      if (feat == FEAT_CONST) rd_d = 32'(const_q);
      if (feat == FEAT_PE)    rd_d = 32'(pe_cfg_q);
      if (feat == FEAT_CB0)   rd_d = 32'(cb_q[0]);
      if (feat == FEAT_CB1)   rd_d = 32'(cb_q[1]);
      for (int s = 0; s < 4; s++)
        if (feat == FEAT_SB_BASE + 16'(s)) rd_d = 32'(sb_q[s]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  assign config_rd_data = rd_q;
`else
  assign config_rd_data = '0;
`endif

endmodule

// File: tb/tb_pe_tile_param.sv
// tb/tb_pe_tile_param.sv - directed, table-driven bench for pe_tile_param (WIDTH=16, 4 tracks)
module tb_pe_tile_param;
  import pe_tile_pkg::*;

  localparam int W  = 16;
  localparam int NT = 4;
  localparam logic [15:0] TID = 16'h0003;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       config_addr, config_data;
  logic              config_we, config_rd_en;
  logic [31:0]       config_rd_data;
  logic [15:0]       tile_id;
  logic [4*NT*W-1:0] in_tracks, out_tracks;

  int checks = 0;
  int errors = 0;

  pe_tile_param #(.WIDTH(W), .NUM_TRACKS(NT)) dut (
    .clk            (clk),
    .reset          (reset),
    .config_addr    (config_addr),
    .config_data    (config_data),
    .config_we      (config_we),
    .config_rd_en   (config_rd_en),
    .config_rd_data (config_rd_data),
    .tile_id        (tile_id),
    .in_tracks      (in_tracks),
    .out_tracks     (out_tracks)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  cfg;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cfg_wr(input logic [15:0] feat, input logic [31:0] data, input logic [15:0] tgt);
    @(negedge clk);
    config_addr = {feat, tgt};
    config_data = data;
    config_we   = 1'b1;
    @(posedge clk);
    #1;
    config_we   = 1'b0;
  endtask

  task automatic set_in(input int s, input int t, input logic [15:0] v);
    in_tracks[(s*NT+t)*W +: W] = v;
  endtask

  function automatic logic [15:0] get_out(input int s, input int t);
    return out_tracks[(s*NT+t)*W +: W];
  endfunction

  initial begin
    vecs[0]  = '{6'h00, 16'h0005, 16'h0007, 16'h000C};
    vecs[1]  = '{6'h01, 16'h0003, 16'h0005, 16'hFFFE};
    vecs[2]  = '{6'h02, 16'hF0F0, 16'hFF00, 16'hF000};
    vecs[3]  = '{6'h03, 16'hF0F0, 16'h0F00, 16'hFFF0};
    vecs[4]  = '{6'h04, 16'hFFFF, 16'h0F0F, 16'hF0F0};
    vecs[5]  = '{6'h05, 16'h8000, 16'h0001, 16'h0001};
    vecs[6]  = '{6'h06, 16'h8000, 16'h0001, 16'h8000};
    vecs[7]  = '{6'h07, 16'h1234, 16'h5678, 16'h1234};
    vecs[8]  = '{6'h00, 16'hFFFF, 16'h0002, 16'h0001};
    vecs[9]  = '{6'h01, 16'h0000, 16'h0001, 16'hFFFF};
    vecs[10] = '{6'h10, 16'h0005, 16'h0007, 16'h000C};
    vecs[11] = '{6'h22, 16'h0FFF, 16'hFFFF, 16'h00F0};
    vecs[12] = '{6'h26, 16'h0100, 16'hFFFF, 16'h0100};
    vecs[13] = '{6'h26, 16'h0010, 16'hFFFF, 16'h00F0};

    reset = 1'b1; config_addr = '0; config_data = '0; config_we = 1'b0;
    config_rd_en = 1'b0; tile_id = TID; in_tracks = {(4*NT){16'hA5A5}};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_out_zero", 32'(out_tracks == '0), 32'd1);
    check("reset_rd_zero", config_rd_data, 32'd0);

    in_tracks = '0;
    set_in(3, 0, 16'hBEEF);
    cfg_wr(FEAT_SB_BASE + 16'd1, 32'h002, 16'h0004);
    check("other_tile_ignored", 32'(get_out(1, 0)), 32'h0);
    cfg_wr(FEAT_SB_BASE + 16'd1, 32'h002, TID);
    check("sb_side1_from3", 32'(get_out(1, 0)), 32'hBEEF);
    set_in(3, 0, 16'h1234);
    #1 check("sb_comb_follow", 32'(get_out(1, 0)), 32'h1234);

    set_in(1, 2, 16'h1111);
    cfg_wr(FEAT_SB_BASE + 16'd0, 32'h040, TID);
    check("sb_side0_t2_from1", 32'(get_out(0, 2)), 32'h1111);
    set_in(2, 3, 16'h2222);
    cfg_wr(FEAT_SB_BASE + 16'd3, 32'h600, TID);
    check("sb_side3_t3_from2", 32'(get_out(3, 3)), 32'h2222);
    cfg_wr(FEAT_SB_BASE + 16'd1, 32'h007, TID);
    check("sb_sel7_zero", 32'(get_out(1, 0)), 32'h0);
    cfg_wr(16'd2, 32'hFFFF_FFFF, TID);
    check("unknown_feat_ignored", 32'(get_out(3, 3)), 32'h2222);

    cfg_wr(FEAT_CB0, 32'd1, TID);
    cfg_wr(FEAT_CB1, 32'd2, TID);
    cfg_wr(FEAT_SB_BASE + 16'd2, 32'h004, TID);
    cfg_wr(FEAT_CONST, 32'h00F0, TID);

    for (int i = 0; i < 14; i++) begin
      set_in(0, 1, vecs[i].a);
      set_in(1, 2, vecs[i].b);
      cfg_wr(FEAT_PE, 32'(vecs[i].cfg), TID);
      check($sformatf("alu_vec%0d", i), 32'(get_out(2, 0)), 32'(vecs[i].exp));
    end

    // CB1 taps out track (1,1), which the switch box feeds from in (3,1)
    cfg_wr(FEAT_SB_BASE + 16'd1, 32'h010, TID);
    cfg_wr(FEAT_CB1, 32'd5, TID);
    set_in(3, 1, 16'h0007);
    set_in(0, 1, 16'h0005);
    cfg_wr(FEAT_PE, 32'h00, TID);
    check("cb1_from_out_track", 32'(get_out(2, 0)), 32'h000C);
    cfg_wr(FEAT_CB1, 32'd2, TID);

    set_in(0, 1, 16'h0002);
    set_in(1, 2, 16'h0003);
    cfg_wr(FEAT_PE, 32'h08, TID);
    check("regout_cleared", 32'(get_out(2, 0)), 32'h0);
    @(posedge clk); #1;
    check("regout_latency", 32'(get_out(2, 0)), 32'h5);
    @(negedge clk);
    set_in(0, 1, 16'h000A);
    #1 check("regout_holds", 32'(get_out(2, 0)), 32'h5);
    @(posedge clk); #1;
    check("regout_update", 32'(get_out(2, 0)), 32'hD);

    set_in(0, 1, 16'h0001);
    cfg_wr(FEAT_PE, 32'h18, TID);
    check("acc_start", 32'(get_out(2, 0)), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("acc_step%0d", i), 32'(get_out(2, 0)), 32'(i));
    end
    cfg_wr(FEAT_PE, 32'h18, TID);
    check("acc_rewrite_clear", 32'(get_out(2, 0)), 32'h0);
    @(posedge clk); #1;
    check("acc_after_clear", 32'(get_out(2, 0)), 32'h1);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_mid_acc", 32'(out_tracks == '0), 32'd1);

    @(negedge clk);
    reset = 1'b1;
    config_addr = {FEAT_SB_BASE + 16'd1, TID};
    config_data = 32'h002;
    config_we = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    config_we = 1'b0;
    set_in(3, 0, 16'hBEEF);
    #1 check("reset_beats_write", 32'(get_out(1, 0)), 32'h0);

`ifdef PE_TILE_CFG_READBACK_EN
    cfg_wr(FEAT_CB0, 32'd5, TID);
    @(negedge clk);
    config_addr = {FEAT_CB0, TID};
    config_rd_en = 1'b1;
    @(posedge clk); #1;
    config_rd_en = 1'b0;
    check("rb_cb0", config_rd_data, 32'd5);
    @(posedge clk); #1;
    check("rb_idle_zero", config_rd_data, 32'd0);
    @(negedge clk);
    config_data = 32'd2;
    config_we = 1'b1;
    config_rd_en = 1'b1;
    @(posedge clk); #1;
    config_we = 1'b0;
    config_rd_en = 1'b0;
    check("rb_old_value", config_rd_data, 32'd5);
    @(negedge clk);
    config_rd_en = 1'b1;
    @(posedge clk); #1;
    config_rd_en = 1'b0;
    check("rb_new_value", config_rd_data, 32'd2);
`else
    cfg_wr(FEAT_CB0, 32'd5, TID);
    @(negedge clk);
    config_addr = {FEAT_CB0, TID};
    config_rd_en = 1'b1;
    @(posedge clk); #1;
    config_rd_en = 1'b0;
    check("rb_disabled_zero", config_rd_data, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
